// File: rtl/sme_writeback.sv
// Writeback stage for masked (shared) ALU results: passes shares through or recombines them into one GPR value.
// Latency: 1 cycle for share writes; d cycles for an unmask (one share folded in per cycle after accept).
// Backpressure: single result in flight; out_* held stable until out_ready, in_ready low while busy or flushing.
module sme_writeback #(
  parameter int XLEN = 32,
  parameter int SMAX = 4
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  output logic                       g_clk_req,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_unmask,
  input  logic [4:0]                 in_rd_addr,
  input  logic                       smectl_t,
  input  logic [3:0]                 smectl_d,
  input  logic [SMAX-1:0][XLEN-1:0]  in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_rd_addr,
  output logic                       out_unmasked,
  output logic [XLEN-1:0]            out_gpr,
  output logic [SMAX-1:0][XLEN-1:0]  out_shares,
  output logic [SMAX-1:0]            out_share_en
);

  // Wide enough to hold share counts 0..SMAX inclusive.
  localparam int DW = $clog2(SMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;

  logic [DW-1:0]             d_eff;
  logic [DW-1:0]             d_q;
  logic [DW-1:0]             cnt;
  logic                      t_q;
  logic                      unmask_q;
  logic [4:0]                addr_q;
  logic [SMAX-1:0][XLEN-1:0] shares_q;
  logic [XLEN-1:0]           acc;
  logic [XLEN-1:0]           share_sel;
  logic [XLEN-1:0]           acc_step;
  logic                      accept;
  logic                      last_share;
  logic                      clear;

  assign in_ready = (state == ST_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Leaving OUT or flushing wipes every captured share so nothing lingers.
  assign clear    = flush || ((state == ST_OUT) && out_ready);

  // Clamp the requested share count into 1..SMAX.
  always_comb begin
    if (smectl_d == 4'd0) begin
      d_eff = DW'(1);
    end else if (int'(smectl_d) > SMAX) begin
      d_eff = DW'(SMAX);
    end else begin
      d_eff = DW'(smectl_d);
    end
  end

  // Select the share addressed by cnt; out-of-range counts read as zero.
  always_comb begin
    share_sel = '0;
    for (int i = 0; i < SMAX; i++) begin
      if (int'(cnt) == i) begin
        share_sel = shares_q[i];
      end
    end
  end

  // One share per cycle: XOR for boolean masking, modular add for arithmetic.
  assign acc_step   = t_q ? (acc + share_sel) : (acc ^ share_sel);
  assign last_share = (cnt == (d_q - DW'(1)));

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_nxt = (!in_unmask || (d_eff == DW'(1))) ? ST_OUT : ST_ACC;
          end
        end
        ST_ACC: begin
          if (last_share) begin
            state_nxt = ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Capture the result on accept, fold shares while in ACC, wipe on exit.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      d_q      <= '0;
      cnt      <= '0;
      t_q      <= 1'b0;
      unmask_q <= 1'b0;
      addr_q   <= '0;
      shares_q <= '0;
      acc      <= '0;
    end else if (clear) begin
      d_q      <= '0;
      cnt      <= '0;
      t_q      <= 1'b0;
      unmask_q <= 1'b0;
      addr_q   <= '0;
      shares_q <= '0;
      acc      <= '0;
    end else if (accept) begin
      d_q      <= d_eff;
      t_q      <= smectl_t;
      unmask_q <= in_unmask;
      addr_q   <= in_rd_addr;
      acc      <= in_unmask ? in_rd[0] : '0;
      cnt      <= in_unmask ? DW'(1) : '0;
      for (int i = 0; i < SMAX; i++) begin
        shares_q[i] <= (i < int'(d_eff)) ? in_rd[i] : '0;
      end
    end else if (state == ST_ACC) begin
      acc <= acc_step;
      cnt <= cnt + DW'(1);
    end
  end

  assign out_valid    = (state == ST_OUT);
  assign g_clk_req    = (state != ST_IDLE);
  assign out_unmasked = out_valid && unmask_q;
  assign out_gpr      = out_unmasked ? acc : '0;
  assign out_shares   = (out_valid && !unmask_q) ? shares_q : '0;
  assign out_rd_addr  = addr_q;

  // Enable the low d lanes, only while a writeback is being offered.
  always_comb begin
    out_share_en = '0;
    for (int i = 0; i < SMAX; i++) begin
      out_share_en[i] = out_valid && (i < int'(d_q));
    end
  end

endmodule
